// File: rtl/alu_arbiter.sv
// alu_arbiter: two-master round-robin sequencer for the shared 4-bit ALU.
// Define ALU_TIMEOUT_EN to bound WAIT_MUL by TIMEOUT cycles.
module alu_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [1:0] Op0,
  input  logic [1:0] Op1,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       Ack0,
  output logic       Ack1,
  output logic [7:0] Res,
  output logic       Cout,
  output logic       Err,
  output logic       Busy,
  output logic [3:0] Alu_A,
  output logic [3:0] Alu_B,
  output logic [1:0] Alu_Sel,
  output logic       Alu_Init,
  input  logic [7:0] Alu_Sal,
  input  logic       Alu_Cout,
  input  logic       Alu_Done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ADD,
    WAIT_MUL,
    RESP
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] res_q, res_d;
  logic       cout_q, cout_d;
  logic       err_q, err_d;
  logic       pick1;

  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT must be 4..255");
  end

`ifdef ALU_TIMEOUT_EN
  localparam logic [7:0] TO8 = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
`else
  logic first_q, first_d;
`endif

  // tie goes to the master not served last
  assign pick1 = Req1 && (!Req0 || !last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef ALU_TIMEOUT_EN
    cnt_d   = cnt_q;
`else
    first_d = first_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          gnt_d   = pick1;
          op_d    = pick1 ? Op1 : Op0;
          a_d     = pick1 ? A1 : A0;
          b_d     = pick1 ? B1 : B0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unique case (op_q)
          2'b10: begin
            state_d = WAIT_MUL;
`ifdef ALU_TIMEOUT_EN
            cnt_d   = 8'd1;
`else
            first_d = 1'b1;
`endif
          end
          2'b11: begin
            res_d   = 8'h00;
            cout_d  = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end
          default: state_d = WAIT_ADD;
        endcase
      end
      WAIT_ADD: begin
        res_d   = Alu_Sal;
        cout_d  = Alu_Cout;
        state_d = RESP;
      end
      WAIT_MUL: begin
`ifdef ALU_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
        // Done in the first cycle may be left over from a prior multiply
        if (Alu_Done && cnt_q >= 8'd2) begin
          res_d   = Alu_Sal;
          cout_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= TO8) begin
          res_d   = 8'h00;
          cout_d  = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`else
        first_d = 1'b0;
        // Done in the first cycle may be left over from a prior multiply
        if (Alu_Done && !first_q) begin
          res_d   = Alu_Sal;
          cout_d  = 1'b0;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      res_q   <= 8'h00;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`else
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef ALU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`else
      first_q <= first_d;
`endif
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Ack0     = (state_q == RESP) && !gnt_q;
  assign Ack1     = (state_q == RESP) && gnt_q;
  assign Res      = res_q;
  assign Cout     = cout_q;
  assign Err      = err_q;
  assign Alu_A    = Busy ? a_q : 4'h0;
  assign Alu_B    = Busy ? b_q : 4'h0;
  assign Alu_Sel  = Busy ? op_q : 2'b00;
  assign Alu_Init = (state_q == ISSUE) && (op_q == 2'b10);

endmodule
